// File: rtl/note_sequencer.sv
// Note sequencer: steps through a (voice, duration) table, requests one
// sample per divided tick from the selected generator and hands it
// downstream over a valid/ready handshake.
module note_sequencer #(
    parameter int width_p     = 12,
    parameter int voices_p    = 4,
    parameter int steps_p     = 8,
    parameter int dur_width_p = 16,
    parameter int clk_div_p   = 2268
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 start_i,
    input  logic                                 stop_i,
    input  logic                                 loop_i,
    input  logic [steps_p*$clog2(voices_p)-1:0]  step_voice_i,
    input  logic [steps_p*dur_width_p-1:0]       step_dur_i,
    input  logic [voices_p*width_p-1:0]          voice_data_i,
    output logic [voices_p-1:0]                  voice_ready_o,
    output logic [width_p-1:0]                   data_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic                                 busy_o,
    output logic [$clog2(steps_p)-1:0]           step_o,
    output logic                                 overrun_o
);
    localparam int vidx_w = $clog2(voices_p);
    localparam int step_w = $clog2(steps_p);
    localparam int cnt_w  = $clog2(clk_div_p);
    localparam int zc_w   = $clog2(steps_p + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADV, S_WAIT, S_REQ, S_SET1, S_SET2, S_OUT
    } state_t;

    state_t                   state;
    logic [cnt_w-1:0]         div_cnt;
    logic                     tick;
    logic [dur_width_p-1:0]   remaining;
    logic [vidx_w-1:0]        sel_voice;
    logic [zc_w-1:0]          zero_cnt;

    logic [vidx_w-1:0]        cur_voice;
    logic                     last_step;
    logic [step_w-1:0]        nxt_step;
    logic [dur_width_p-1:0]   nxt_dur;
    logic [dur_width_p-1:0]   dur0;
    logic [voices_p-1:0]      req_onehot;
    logic [width_p-1:0]       sel_data;

    assign busy_o    = (state != S_IDLE);
    assign tick      = busy_o && (div_cnt == cnt_w'(clk_div_p - 1));
    assign cur_voice = step_voice_i[step_o*vidx_w +: vidx_w];
    assign last_step = (step_o == step_w'(steps_p - 1));
    assign nxt_step  = last_step ? '0 : step_o + step_w'(1);
    assign nxt_dur   = step_dur_i[nxt_step*dur_width_p +: dur_width_p];
    assign dur0      = step_dur_i[dur_width_p-1:0];

    // One-hot request for the current step's voice; out-of-range voices request nothing
    always_comb begin
        req_onehot = '0;
        if (int'(cur_voice) < voices_p) req_onehot[cur_voice] = 1'b1;
    end

    // Sample mux for the voice latched at REQ; out-of-range voices read as zero
    always_comb begin
        sel_data = '0;
        if (int'(sel_voice) < voices_p)
            sel_data = voice_data_i[int'(sel_voice)*width_p +: width_p];
    end

    // Sample-rate divider: free-runs while playing, parked at zero in IDLE so start begins a fresh period
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                div_cnt <= '0;
        else if (state == S_IDLE)   div_cnt <= '0;
        else if (tick)              div_cnt <= '0;
        else                        div_cnt <= div_cnt + cnt_w'(1);
    end

    // Sequencer FSM with registered outputs; stop_i overrides everything
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= S_IDLE;
            voice_ready_o <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            step_o        <= '0;
            overrun_o     <= 1'b0;
            remaining     <= '0;
            sel_voice     <= '0;
            zero_cnt      <= '0;
        end else begin
            voice_ready_o <= '0;
            overrun_o     <= 1'b0;
            if (stop_i) begin
                state   <= S_IDLE;
                valid_o <= 1'b0;
                step_o  <= '0;
            end else begin
                // a tick while still holding a sample is lost
                if (state == S_OUT && tick) overrun_o <= 1'b1;
                case (state)
                    S_IDLE: if (start_i) begin
                        step_o    <= '0;
                        remaining <= dur0;
                        zero_cnt  <= (dur0 == '0) ? zc_w'(1) : '0;
                        state     <= S_ADV;
                    end
                    S_ADV: begin
                        if (remaining == '0) begin
                            if (last_step && !loop_i) begin
                                state  <= S_IDLE;
                                step_o <= '0;
                            end else if (nxt_dur == '0 &&
                                         zero_cnt + zc_w'(1) >= zc_w'(steps_p)) begin
                                // a whole table's worth of empty steps: nothing to play
                                state  <= S_IDLE;
                                step_o <= '0;
                            end else begin
                                step_o    <= nxt_step;
                                remaining <= nxt_dur;
                                zero_cnt  <= (nxt_dur == '0) ? zero_cnt + zc_w'(1) : '0;
                            end
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: if (tick) begin
                        sel_voice     <= cur_voice;
                        voice_ready_o <= req_onehot;
                        state         <= S_REQ;
                    end
                    S_REQ:  state <= S_SET1;
                    S_SET1: state <= S_SET2;
                    S_SET2: begin
                        data_o  <= sel_data;
                        valid_o <= 1'b1;
                        state   <= S_OUT;
                    end
                    S_OUT: if (ready_i) begin
                        valid_o   <= 1'b0;
                        remaining <= remaining - dur_width_p'(1);
                        state     <= (remaining == dur_width_p'(1)) ? S_ADV : S_WAIT;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
